traffic_phase_sequencer: RTL and testbench

//  Master timing FSM for the two-road crossing model. Drives StateFlag, the 2-bit phase code consumed by
//  the 40-pin header decoder: 0=Principal Green, 1=Principal Yellow, 2=Secondary Green, 3=Secondary Yellow.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 27 ++
 rtl/traffic_phase_sequencer.sv | 90 +++++++++
 tb/tb_traffic_phase_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase codes for the crossing model; the header decoder uses the same constants.
// Also provides the fixed phase-succession rule.
package traffic_pkg;

   localparam logic [1:0] PH_PGREEN  = 2'd0;
   localparam logic [1:0] PH_PYELLOW = 2'd1;
   localparam logic [1:0] PH_SGREEN  = 2'd2;
   localparam logic [1:0] PH_SYELLOW = 2'd3;

   typedef enum logic [1:0] {
      ST_PGREEN  = PH_PGREEN,
      ST_PYELLOW = PH_PYELLOW,
      ST_SGREEN  = PH_SGREEN,
      ST_SYELLOW = PH_SYELLOW
   } phase_t;

   function automatic phase_t next_phase(input phase_t cur);
      case (cur)
         ST_PGREEN:  next_phase = ST_PYELLOW;
         ST_PYELLOW: next_phase = ST_SGREEN;
         ST_SGREEN:  next_phase = ST_SYELLOW;
         default:    next_phase = ST_PGREEN;
      endcase
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle Tick every TICK_DIV cycles.
// Hold freezes the count in place and suppresses the tick.
module tick_prescaler #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Hold,
   output logic Tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt <= '0;
      end else if (!Hold) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign Tick = (cnt == LAST) && !Hold;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Master timing FSM for the two-road crossing: sequences PG/PY/SG/SY in whole seconds
// and holds Principal Green until the secondary-road sensor has asked for service.
module traffic_phase_sequencer
   import traffic_pkg::*;
#(
   parameter int TICK_DIV  = 50_000_000,
   parameter int T_PGREEN  = 20,
   parameter int T_PYELLOW = 3,
   parameter int T_SGREEN  = 10,
   parameter int T_SYELLOW = 3
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       CarSensor,
   input  logic       Hold,
   output logic [1:0] StateFlag,
   output logic [7:0] SecondsLeft,
   output logic       PhaseStart,
   output logic       Waiting
);

   if (TICK_DIV < 2 ||
       T_PGREEN  < 1 || T_PGREEN  > 255 || T_PYELLOW < 1 || T_PYELLOW > 255 ||
       T_SGREEN  < 1 || T_SGREEN  > 255 || T_SYELLOW < 1 || T_SYELLOW > 255) begin : g_bad_params
      $error("traffic_phase_sequencer: TICK_DIV must be >=2 and every T_* must be 1..255");
   end

   function automatic logic [7:0] phase_len(input phase_t ph);
      case (ph)
         ST_PGREEN:  phase_len = 8'(T_PGREEN);
         ST_PYELLOW: phase_len = 8'(T_PYELLOW);
         ST_SGREEN:  phase_len = 8'(T_SGREEN);
         default:    phase_len = 8'(T_SYELLOW);
      endcase
   endfunction

   phase_t phase;
   logic   tick;
   logic   sync1, car_sync;
   logic   demand_latched;
   logic   expiry, advance, enter_sg;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .Clock (Clock),
      .Reset (Reset),
      .Hold  (Hold),
      .Tick  (tick)
   );

   // A request arriving on the expiry tick itself counts, so CarSync is used directly too.
   assign expiry   = tick && (SecondsLeft == 8'd1);
   assign advance  = expiry && ((phase != ST_PGREEN) || demand_latched || car_sync);
   assign enter_sg = advance && (phase == ST_PYELLOW);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync1          <= 1'b0;
         car_sync       <= 1'b0;
         demand_latched <= 1'b0;
         phase          <= ST_PGREEN;
         SecondsLeft    <= 8'(T_PGREEN);
         PhaseStart     <= 1'b0;
         Waiting        <= 1'b0;
      end else begin
         sync1      <= CarSensor;
         car_sync   <= sync1;
         PhaseStart <= 1'b0;

         if (advance) begin
            phase       <= next_phase(phase);
            SecondsLeft <= phase_len(next_phase(phase));
            PhaseStart  <= 1'b1;
            Waiting     <= 1'b0;
         end else if (expiry) begin
            Waiting <= 1'b1;
         end else if (tick) begin
            SecondsLeft <= SecondsLeft - 8'd1;
         end

         // Serving the secondary road consumes the demand; a fresh request that same cycle survives.
         if (enter_sg)
            demand_latched <= car_sync;
         else if (car_sync)
            demand_latched <= 1'b1;
      end
   end

   assign StateFlag = phase;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with a 4-cycle tick and short phase times.
module tb_traffic_phase_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       car = 1'b0;
   logic       hold = 1'b0;
   logic [1:0] sf;
   logic [7:0] sl;
   logic       ps;
   logic       wt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   traffic_phase_sequencer #(
      .TICK_DIV (4),
      .T_PGREEN (3),
      .T_PYELLOW(2),
      .T_SGREEN (2),
      .T_SYELLOW(1)
   ) dut (
      .Clock      (clk),
      .Reset      (rst),
      .CarSensor  (car),
      .Hold       (hold),
      .StateFlag  (sf),
      .SecondsLeft(sl),
      .PhaseStart (ps),
      .Waiting    (wt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   // Leaves the bench inside cycle 0: prescaler count 0, reset values showing.
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      logic [1:0] exp_sf;
      logic       exp_ps;

      // 1: sensor held high, full cycle of phases
      car = 1'b1;
      do_reset();
      check("rst_sf", 8'(sf), 8'd0);
      check("rst_sl", sl, 8'd3);
      check("rst_ps", 8'(ps), 8'd0);
      check("rst_wt", 8'(wt), 8'd0);
      for (int c = 0; c < 40; c++) begin
         if (c < 12)      exp_sf = 2'd0;
         else if (c < 20) exp_sf = 2'd1;
         else if (c < 28) exp_sf = 2'd2;
         else if (c < 32) exp_sf = 2'd3;
         else             exp_sf = 2'd0;
         exp_ps = (c == 12 || c == 20 || c == 28 || c == 32);
         check("t1_sf", 8'(sf), 8'(exp_sf));
         check("t1_ps", 8'(ps), 8'(exp_ps));
         if (c == 12) check("t1_sl_py", sl, 8'd2);
         if (c == 20) check("t1_sl_sg", sl, 8'd2);
         if (c == 32) check("t1_sl_pg", sl, 8'd3);
         step();
      end

      // 2: no demand -> PG waits, late pulse releases it
      car = 1'b0;
      do_reset();
      run_to(11);
      check("t2_wt_pre", 8'(wt), 8'd0);
      run_to(12);
      check("t2_wt", 8'(wt), 8'd1);
      check("t2_sf", 8'(sf), 8'd0);
      check("t2_sl", sl, 8'd1);
      run_to(20);
      car = 1'b1;
      step();
      car = 1'b0;
      run_to(23);
      check("t2_sf_hold", 8'(sf), 8'd0);
      check("t2_wt_hold", 8'(wt), 8'd1);
      run_to(24);
      check("t2_sf_py", 8'(sf), 8'd1);
      check("t2_ps_py", 8'(ps), 8'd1);
      check("t2_wt_py", 8'(wt), 8'd0);
      check("t2_sl_py", sl, 8'd2);

      // 3: pulse during PY survives the SG-entry clear, so the next PG does not wait
      car = 1'b1;
      do_reset();
      run_to(5);
      car = 1'b0;
      run_to(17);
      check("t3_sf_py", 8'(sf), 8'd1);
      car = 1'b1;
      step();
      car = 1'b0;
      run_to(32);
      check("t3_sf_pg", 8'(sf), 8'd0);
      check("t3_sl_pg", sl, 8'd3);
      run_to(43);
      check("t3_sf_last", 8'(sf), 8'd0);
      check("t3_wt_last", 8'(wt), 8'd0);
      run_to(44);
      check("t3_sf_py2", 8'(sf), 8'd1);
      check("t3_ps_py2", 8'(ps), 8'd1);
      check("t3_wt_py2", 8'(wt), 8'd0);

      // 4: Hold for 10 cycles early in SG
      car = 1'b1;
      do_reset();
      run_to(20);
      check("t4_sf_sg", 8'(sf), 8'd2);
      check("t4_sl_sg", sl, 8'd2);
      run_to(21);
      hold = 1'b1;
      for (int c = 21; c < 31; c++) begin
         check("t4_sf_hold", 8'(sf), 8'd2);
         check("t4_sl_hold", sl, 8'd2);
         step();
      end
      hold = 1'b0;
      run_to(33);
      check("t4_sl_resume", sl, 8'd2);
      run_to(34);
      check("t4_sl_dec", sl, 8'd1);
      run_to(37);
      check("t4_sf_sg_end", 8'(sf), 8'd2);
      run_to(38);
      check("t4_sf_sy", 8'(sf), 8'd3);
      check("t4_ps_sy", 8'(ps), 8'd1);
      hold = 1'b0;

      // 5: reset during SY with a demand pending
      car = 1'b1;
      do_reset();
      run_to(5);
      car = 1'b0;
      run_to(22);
      car = 1'b1;
      step();
      car = 1'b0;
      run_to(29);
      check("t5_sf_sy", 8'(sf), 8'd3);
      check("t5_dem_pre", 8'(dut.demand_latched), 8'd1);
      do_reset();
      check("t5_sf", 8'(sf), 8'd0);
      check("t5_sl", sl, 8'd3);
      check("t5_wt", 8'(wt), 8'd0);
      check("t5_ps", 8'(ps), 8'd0);
      check("t5_dem", 8'(dut.demand_latched), 8'd0);
      run_to(12);
      check("t5_wt_after", 8'(wt), 8'd1);
      check("t5_sf_after", 8'(sf), 8'd0);

      // 6: CarSync rises exactly on the PG expiry tick
      car = 1'b0;
      do_reset();
      run_to(9);
      car = 1'b1;
      step();
      car = 1'b0;
      run_to(11);
      check("t6_dem", 8'(dut.demand_latched), 8'd0);
      check("t6_sf_pre", 8'(sf), 8'd0);
      run_to(12);
      check("t6_sf", 8'(sf), 8'd1);
      check("t6_ps", 8'(ps), 8'd1);
      check("t6_wt", 8'(wt), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
